// File: rtl/seq_det_scheduler_if.sv
// -----------------------------------------------------------------------------
// seq_det_scheduler_if
// Bundles the channel-side handshake, the shared detector pins and the
// per-frame result bus of seq_det_scheduler.
//
// Parameters:
//   N      number of requesting channels
//   CNT_W  width of the per-frame hit count
//
// Signals:
//   req, ch_data, ch_last   channel -> scheduler (N bits each)
//   gnt, bit_ack            scheduler -> channel (N bits each)
//   det_reset, det_data     scheduler -> detector
//   det_hit                 detector  -> scheduler
//   res_valid, res_ch,
//   res_count, res_abort    scheduler -> result consumer
//
// Modports:
//   master  the scheduler side
//   slave   channels, detector and result consumer
// -----------------------------------------------------------------------------
interface seq_det_scheduler_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N-1:0]     ch_data;
  logic [N-1:0]     ch_last;
  logic [N-1:0]     gnt;
  logic [N-1:0]     bit_ack;
  logic             det_reset;
  logic             det_data;
  logic             det_hit;
  logic             res_valid;
  logic [SEL_W-1:0] res_ch;
  logic [CNT_W-1:0] res_count;
  logic             res_abort;

  modport master (
    input  req, ch_data, ch_last, det_hit,
    output gnt, bit_ack, det_reset, det_data,
           res_valid, res_ch, res_count, res_abort
  );

  modport slave (
    output req, ch_data, ch_last, det_hit,
    input  gnt, bit_ack, det_reset, det_data,
           res_valid, res_ch, res_count, res_abort
  );
endinterface

// File: rtl/seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// seq_det_scheduler
// Round-robin scheduler sharing one sequence detector among N serial channels.
// For each granted channel it clears the detector, streams one frame of bits
// into it, waits out the detector latency, counts aligned hits and reports a
// one-cycle result strobe.
//
// Parameters:
//   N          number of channels (2..16)
//   CNT_W      width of the saturating per-frame hit counter
//   DET_LAT    detector latency from det_data to det_hit (1..4)
//   MAX_FRAME  frame length limit, only used when SEQ_SCHED_TIMEOUT_EN is set
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    seq_det_scheduler_if.master (req/ch_data/ch_last in, gnt/bit_ack
//          out, detector pins, result bus)
//
// Build option:
//   SEQ_SCHED_TIMEOUT_EN  when defined, a frame reaching MAX_FRAME bits
//                         without ch_last is cut short and reported with
//                         res_abort=1; otherwise res_abort is tied low.
// -----------------------------------------------------------------------------
module seq_det_scheduler #(
  parameter int N         = 4,
  parameter int CNT_W     = 8,
  parameter int DET_LAT   = 1,
  parameter int MAX_FRAME = 256
) (
  input logic                 clk,
  input logic                 reset,
  seq_det_scheduler_if.master bus
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int DRN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DRN_W-1:0] DRN_END = DRN_W'(DET_LAT - 1);
  localparam logic [SEL_W-1:0] SEL_END = SEL_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [N-1:0]       gnt_q,       gnt_d;
  logic [SEL_W-1:0]   sel_q,       sel_d;
  logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic               skip_q,      skip_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [DET_LAT-1:0] pipe_q,      pipe_d;
  logic [DRN_W-1:0]   drain_q,     drain_d;
  logic               res_valid_q, res_valid_d;
  logic [SEL_W-1:0]   res_ch_q,    res_ch_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;

`ifdef SEQ_SCHED_TIMEOUT_EN
  localparam int BIT_W = $clog2(MAX_FRAME + 1);
  localparam logic [BIT_W-1:0] BIT_END = BIT_W'(MAX_FRAME - 1);

  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic               abort_q,     abort_d;
  logic               res_abort_q, res_abort_d;
`endif

  logic [N-1:0]       req_eff;
  logic [DET_LAT-1:0] pipe_shift;
  logic               hit_ok;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cur_last;

  // First requester at or after ptr, wrapping around the channel ring.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0]     r,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && r[idx]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Bit-valid pipe: a 1 enters for every STREAM cycle and emerges DET_LAT
  // cycles later, exactly when the detector answers for that bit.
  always_comb begin
    pipe_shift    = '0;
    pipe_shift[0] = (state_q == STREAM);
    for (int i = 1; i < DET_LAT; i++) begin
      pipe_shift[i] = pipe_q[i-1];
    end
  end

  // Hit qualification and saturating increment.
  always_comb begin
    hit_ok = pipe_q[DET_LAT-1] & bus.det_hit;
    if (hit_ok && (cnt_q != CNT_MAX)) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end else begin
      cnt_inc = cnt_q;
    end
  end

  // Requests seen in IDLE; the channel just served is masked for one cycle
  // so a request still held after its result does not retrigger.
  always_comb begin
    if (skip_q) begin
      req_eff = bus.req & ~(ONE_N << sel_q);
    end else begin
      req_eff = bus.req;
    end
    cur_last = bus.ch_last[sel_q];
  end

  // Next-state logic for the scheduler FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    pipe_d      = pipe_shift;
    drain_d     = drain_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_count_d = res_count_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
    bit_cnt_d   = bit_cnt_q;
    abort_d     = abort_q;
    res_abort_d = res_abort_q;
`endif

    case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (|req_eff) begin
          sel_d   = rr_pick(req_eff, rr_ptr_q);
          gnt_d   = ONE_N << rr_pick(req_eff, rr_ptr_q);
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        cnt_d   = '0;
        pipe_d  = '0;
        drain_d = '0;
`ifdef SEQ_SCHED_TIMEOUT_EN
        bit_cnt_d = '0;
        abort_d   = 1'b0;
`endif
        state_d = STREAM;
      end

      STREAM: begin
        cnt_d = cnt_inc;
`ifdef SEQ_SCHED_TIMEOUT_EN
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (cur_last) begin
          state_d = DRAIN;
        end else if (bit_cnt_q == BIT_END) begin
          abort_d = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
`else
        if (cur_last) begin
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
`endif
      end

      DRAIN: begin
        cnt_d = cnt_inc;
        if (drain_q == DRN_END) begin
          // Result registers load from cnt_inc so the final drain-cycle hit
          // is included.
          res_valid_d = 1'b1;
          res_ch_d    = sel_q;
          res_count_d = cnt_inc;
`ifdef SEQ_SCHED_TIMEOUT_EN
          res_abort_d = abort_q;
`endif
          state_d     = REPORT;
        end else begin
          drain_d = drain_q + DRN_W'(1);
          state_d = DRAIN;
        end
      end

      REPORT: begin
        if (sel_q == SEL_END) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = sel_q + SEL_W'(1);
        end
        gnt_d   = '0;
        skip_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      skip_q      <= 1'b0;
      cnt_q       <= '0;
      pipe_q      <= '0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
`ifdef SEQ_SCHED_TIMEOUT_EN
      bit_cnt_q   <= '0;
      abort_q     <= 1'b0;
      res_abort_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      pipe_q      <= pipe_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_count_q <= res_count_d;
`ifdef SEQ_SCHED_TIMEOUT_EN
      bit_cnt_q   <= bit_cnt_d;
      abort_q     <= abort_d;
      res_abort_q <= res_abort_d;
`endif
    end
  end

  // det_data is a mux on the registered grant; the detector is held in
  // reset both by the block reset and by the CLEAR state.
  assign bus.gnt       = gnt_q;
  assign bus.bit_ack   = (state_q == STREAM) ? gnt_q : '0;
  assign bus.det_data  = (state_q == STREAM) ? bus.ch_data[sel_q] : 1'b0;
  assign bus.det_reset = reset | (state_q == CLEAR);
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_count = res_count_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
  assign bus.res_abort = res_abort_q;
`else
  assign bus.res_abort = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_det_scheduler
// Directed bench for seq_det_scheduler with a behavioural overlapping "101"
// detector (latency 1). CNT_W=2 so saturation is reachable with short frames.
// -----------------------------------------------------------------------------
module tb_seq_det_scheduler;
  localparam int N         = 4;
  localparam int CNT_W     = 2;
  localparam int DET_LAT   = 1;
  localparam int MAX_FRAME = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_det_scheduler_if #(.N(N), .CNT_W(CNT_W)) bus ();

  seq_det_scheduler #(
    .N(N), .CNT_W(CNT_W), .DET_LAT(DET_LAT), .MAX_FRAME(MAX_FRAME)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural detector: registered, overlapping match of 1,0,1.
  logic [1:0] hist  = 2'b00;
  logic       det_q = 1'b0;
  always @(posedge clk) begin
    if (bus.det_reset) begin
      hist  <= 2'b00;
      det_q <= 1'b0;
    end else begin
      hist  <= {hist[0], bus.det_data};
      det_q <= ({hist, bus.det_data} == 3'b101);
    end
  end
  assign bus.det_hit = det_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the channel's first bit_ack, then presents len bits.
  task automatic drive_frame(input int ch, input logic [31:0] bits, input int len,
                             input bit with_last, output int acks, output int steps);
    acks  = 0;
    steps = 0;
    while (bus.bit_ack[ch] !== 1'b1 && steps < 20) begin
      step();
      steps++;
    end
    for (int i = 0; i < len; i++) begin
      bus.ch_data[ch] = bits[i];
      bus.ch_last[ch] = with_last && (i == len - 1);
      #1;
      if (bus.bit_ack[ch] === 1'b1) acks++;
      step();
      steps++;
    end
    bus.ch_data[ch] = 1'b0;
    bus.ch_last[ch] = 1'b0;
  endtask

  task automatic poll_res(output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (bus.gnt === '0 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.ch_data = '0; bus.ch_last = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.bit_ack !== 4'b0000) begin errors++; $display("FAIL reset_bit_ack: got %b want 0000", bus.bit_ack); end
    checks++; if (bus.det_data !== 1'b0) begin errors++; $display("FAIL reset_det_data: got %b want 0", bus.det_data); end
    checks++; if (bus.det_reset !== 1'b1) begin errors++; $display("FAIL reset_det_reset: got %b want 1", bus.det_reset); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.res_ch !== 2'd0) begin errors++; $display("FAIL reset_res_ch: got %0d want 0", bus.res_ch); end
    checks++; if (bus.res_count !== 2'd0) begin errors++; $display("FAIL reset_res_count: got %0d want 0", bus.res_count); end
    checks++; if (bus.res_abort !== 1'b0) begin errors++; $display("FAIL reset_res_abort: got %b want 0", bus.res_abort); end
    reset = 1'b0;
    step();
    checks++; if (bus.det_reset !== 1'b0) begin errors++; $display("FAIL idle_det_reset: got %b want 0", bus.det_reset); end
  endtask

  task automatic test_single();
    int acks, steps, n, lat;
    bus.req[2] = 1'b1;
    step();
    lat = 1;
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    checks++; if (bus.det_reset !== 1'b1) begin errors++; $display("FAIL single_clear: got %b want 1", bus.det_reset); end
    drive_frame(2, 32'h15, 5, 1'b1, acks, steps);
    lat += steps;
    checks++; if (acks != 5) begin errors++; $display("FAIL single_acks: got %0d want 5", acks); end
    bus.ch_data = 4'b1111;
    #1;
    checks++; if (bus.bit_ack !== 4'b0000 || bus.det_data !== 1'b0) begin errors++; $display("FAIL drain_quiet: got ack=%b data=%b want 0000/0", bus.bit_ack, bus.det_data); end
    bus.ch_data = 4'b0000;
    poll_res(n);
    lat += n;
    checks++; if (bus.res_valid !== 1'b1 || lat != 7 + DET_LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, 7 + DET_LAT); end
    checks++; if (bus.res_ch !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d want 2", bus.res_ch); end
    checks++; if (bus.res_count !== 2'd2) begin errors++; $display("FAIL single_count: got %0d want 2", bus.res_count); end
    checks++; if (bus.res_abort !== 1'b0) begin errors++; $display("FAIL single_abort: got %b want 0", bus.res_abort); end
    bus.req[2] = 1'b0;
    step();
    checks++; if (bus.res_valid !== 1'b0 || bus.res_count !== 2'd2) begin errors++; $display("FAIL single_strobe_hold: got v=%b c=%0d want 0/2", bus.res_valid, bus.res_count); end
  endtask

  task automatic test_reset_abort();
    int r0;
    bus.req[3] = 1'b1;
    step();
    step();
    bus.ch_data[3] = 1'b1;
    step();
    reset = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.det_reset !== 1'b1) begin errors++; $display("FAIL abort_det_reset: got %b want 1", bus.det_reset); end
    bus.req[3] = 1'b0;
    bus.ch_data[3] = 1'b0;
    r0 = 0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid === 1'b1) r0++;
      step();
    end
    checks++; if (r0 != 0) begin errors++; $display("FAIL abort_no_result: got %0d strobes want 0", r0); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int acks, steps, n;
    logic [3:0] exp_g;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      exp_g = 4'b0001 << order[k];
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, exp_g); end
      drive_frame(order[k], 32'h1, 2, 1'b1, acks, steps);
      poll_res(n);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'(order[k])) begin errors++; $display("FAIL rr_res_ch%0d: got %0d want %0d", k, bus.res_ch, order[k]); end
      if (k == 4) bus.req = 4'b0010;
      step();
    end
    wait_gnt(n);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rr_only1: got %b want 0010", bus.gnt); end
    drive_frame(1, 32'h1, 2, 1'b1, acks, steps);
    poll_res(n);
    step();
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_skip_idle: got %b want 0000", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rr_regrant1: got %b want 0010", bus.gnt); end
    drive_frame(1, 32'h1, 2, 1'b1, acks, steps);
    poll_res(n);
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_isolation();
    int acks, steps, n;
    bus.req = 4'b0011;
    wait_gnt(n);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL iso_gnt0: got %b want 0001", bus.gnt); end
    drive_frame(0, 32'h5, 4, 1'b1, acks, steps);
    poll_res(n);
    checks++; if (bus.res_count !== 2'd1 || bus.res_ch !== 2'd0) begin errors++; $display("FAIL iso_ch0: got ch=%0d c=%0d want 0/1", bus.res_ch, bus.res_count); end
    bus.req[0] = 1'b0;
    step();
    wait_gnt(n);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL iso_gnt1: got %b want 0010", bus.gnt); end
    drive_frame(1, 32'h7, 3, 1'b1, acks, steps);
    poll_res(n);
    checks++; if (bus.res_count !== 2'd0 || bus.res_ch !== 2'd1) begin errors++; $display("FAIL iso_ch1: got ch=%0d c=%0d want 1/0", bus.res_ch, bus.res_count); end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_saturation();
    int acks, steps, n;
    bus.req[3] = 1'b1;
    drive_frame(3, 32'h155, 10, 1'b1, acks, steps);
    poll_res(n);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", bus.res_count); end
    bus.req[3] = 1'b0;
    step();
  endtask

`ifdef SEQ_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int acks, steps, n;
    bit got;
    logic ab;
    logic [CNT_W-1:0] cnt;
    acks = 0; got = 1'b0; ab = 1'b0; cnt = '0;
    bus.req[2] = 1'b1;
    wait_gnt(n);
    step();
    for (int i = 0; i < 20; i++) begin
      bus.ch_data[2] = (i % 2 == 0);
      #1;
      if (bus.bit_ack[2] === 1'b1) acks++;
      if (bus.res_valid === 1'b1) begin
        got = 1'b1; ab = bus.res_abort; cnt = bus.res_count; bus.req[2] = 1'b0;
      end
      step();
    end
    bus.ch_data[2] = 1'b0;
    checks++; if (acks != MAX_FRAME) begin errors++; $display("FAIL to_acks: got %0d want %0d", acks, MAX_FRAME); end
    checks++; if (!got || ab !== 1'b1) begin errors++; $display("FAIL to_abort: got seen=%0d abort=%b want 1/1", got, ab); end
    checks++; if (cnt !== 2'd3) begin errors++; $display("FAIL to_count: got %0d want 3", cnt); end
    bus.req[3] = 1'b1;
    wait_gnt(n);
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL to_next_gnt: got %b want 1000", bus.gnt); end
    drive_frame(3, 32'h5, 3, 1'b1, acks, steps);
    poll_res(n);
    checks++; if (bus.res_abort !== 1'b0 || bus.res_count !== 2'd1) begin errors++; $display("FAIL to_next_res: got a=%b c=%0d want 0/1", bus.res_abort, bus.res_count); end
    bus.req[3] = 1'b0;
    step();
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.ch_data = '0;
    bus.ch_last = '0;
    test_reset();
    test_single();
    test_reset_abort();
    test_round_robin();
    test_isolation();
    test_saturation();
`ifdef SEQ_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Round-robin scheduler that shares one `SequenceDetector` instance among N serial bit-stream channels. Each granted channel streams one frame of bits into the detector. The scheduler clears the detector before each frame, drains its output latency, counts hits, and reports a per-frame result. It sits between the channel front-ends and the detector's `clk`/`reset`/`data_in`/`detected` pins.

## Interface
- `N`, 4, number of requesting channels (2..16)
- `CNT_W`, 8, width of per-frame hit counter
- `DET_LAT`, 1, cycles from a bit at `det_data` to its `det_hit` response (1..4)
- `MAX_FRAME`, 256, frame length limit in bits, used only with the timeout feature
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req`  in  N  channel i has a frame ready; held until its `res_valid`
- `ch_data`  in  N  current bit from each channel
- `ch_last`  in  N  marks the last bit of the frame (qualified by `bit_ack`)
- `gnt`  out  N  one-hot grant, registered
- `bit_ack`  out  N  `gnt[i]` and state==STREAM; the channel's bit is consumed this cycle
- `det_reset`  out  1  to detector `reset`
- `det_data`  out  1  to detector `data_in`
- `det_hit`  in  1  from detector `detected`
- `res_valid`  out  1  one-cycle result strobe
- `res_ch`  out  $clog2(N)  channel of the result
- `res_count`  out  CNT_W  hits in the frame, saturating
- `res_abort`  out  1  frame was aborted (timeout build only; otherwise tied 0)

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- **IDLE:**
  - If `req` is nonzero, pick the first requester at or after `rr_ptr` (wrapping).
  - Load `gnt` and go to CLEAR.
  - If `req` is zero, stay in IDLE.
- **CLEAR:**
  - `det_reset`=1 for exactly one cycle.
  - Clear the hit counter and the valid pipe.
  - Go to STREAM.
- **STREAM:**
  - `det_data` = `ch_data[sel]`, combinational mux on the registered grant.
  - `bit_ack[sel]`=1 every cycle.
  - If `ch_last[sel]`=1, that bit is the final one; go to DRAIN.
- **DRAIN:**
  - Hold for exactly DET_LAT cycles.
  - `det_data`=0 and `bit_ack`=0.
  - Go to REPORT.
- **REPORT:**
  - Assert `res_valid`, `res_ch`=sel, `res_count`.
  - Set `rr_ptr`=(sel+1) mod N and clear `gnt`.
  - Go to IDLE.
  - The channel drops `req` in the same cycle or later. The IDLE cycle that follows ignores `req[sel]` for one cycle, so a held request does not retrigger.
- **Hit alignment:**
  - A DET_LAT-deep shift register carries a "bit valid" flag, set in STREAM cycles.
  - `det_hit` is counted only in cycles where the pipe output is 1. Hits from the previous frame's leftover state or during CLEAR are never counted.
- **Counter:** CNT_W bits, saturating at 2^CNT_W−1, never wraps.
- **Simultaneous events:**
  - A new `req` arriving in REPORT waits for IDLE.
  - `req` deasserted mid-frame is ignored; the frame completes on `ch_last`.
- **Reset** (any state, asynchronous):
  - State→IDLE, `rr_ptr`=0, `gnt`=0, counter=0, pipe=0.
  - `det_reset` = `reset` OR (state==CLEAR), so the detector is also held in reset.
  - An aborted in-flight frame produces no result.

## Timing
- Reset values: `gnt`=0, `bit_ack`=0, `det_data`=0, `res_valid`=0, `res_ch`=0, `res_count`=0, `res_abort`=0; `det_reset`=1 while `reset` is high.
- `req` sampled at cycle t: `gnt` at t+1 (CLEAR) and first `bit_ack` at t+2.
- A frame of L bits occupies cycles t+2..t+L+1. `res_valid` is at t+L+2+DET_LAT.
- Per-frame overhead is 3+DET_LAT cycles (IDLE, CLEAR, DRAIN×DET_LAT, REPORT).
- `res_ch`, `res_count` and `res_abort` are registered and valid only while `res_valid`=1; they hold their values otherwise.

## Configuration
- `SEQ_SCHED_TIMEOUT_EN` defined:
  - A bit counter counts STREAM cycles.
  - If MAX_FRAME bits are consumed without `ch_last`, the scheduler forces DRAIN after the MAX_FRAME-th bit.
  - The REPORT cycle then shows `res_abort`=1 with the hit count so far.
- Not defined: no bit counter; STREAM lasts until `ch_last`, unbounded; `res_abort` is constant 0.

## Test plan
- **Reset:** assert `reset` mid-STREAM → next cycle `gnt`=0 and `det_reset`=1; after release, no `res_valid` for the aborted frame.
- **Single frame:** behavioural detector for pattern 101, DET_LAT=1; channel 2 sends 1,0,1,0,1 (`ch_last` on bit 5) → `res_valid` with `res_ch`=2 and `res_count`=2, 7+DET_LAT cycles after `req`.
- **Round-robin:** all four `req` held high from reset → grant order 0,1,2,3,0; then with only `req[1]` high after serving channel 1 → next grant goes to 1 again only after one idle cycle.
- **Isolation:** channel 0 ends its frame with bits 1,0; channel 1 starts with 1 → channel 1's count excludes the cross-frame 101 (`res_count`=0 for a frame of 1,1,1).
- **Saturation:** CNT_W=2; frame of 10 bits, 1010101010 → `res_count`=3.
- **Timeout** (macro defined, MAX_FRAME=8): 20-bit frame with no `ch_last` → after exactly 8 `bit_ack`, `res_abort`=1; the next requester is granted normally.
